// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light lamp path:
//   - 2-bit controller light codes (LIGHT_*)
//   - one-hot {red, amber, green} lamp patterns (LAMP_*)
//   - lamp_safety_monitor state enum
//   - fault_code cause values (FAULT_*)
//   - decode_light(): light code -> lamp pattern (illegal code shows red)
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef logic [1:0] light_t;
    typedef logic [2:0] lamp_t;

    localparam light_t LIGHT_RED     = 2'b00;
    localparam light_t LIGHT_AMBER   = 2'b01;
    localparam light_t LIGHT_GREEN   = 2'b10;
    localparam light_t LIGHT_ILLEGAL = 2'b11;

    localparam lamp_t LAMP_RED   = 3'b100;
    localparam lamp_t LAMP_AMBER = 3'b010;
    localparam lamp_t LAMP_GREEN = 3'b001;
    localparam lamp_t LAMP_OFF   = 3'b000;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        FLASH   = 2'd1,
        RECOVER = 2'd2
    } monitor_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_CONFLICT = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_BOTH     = 2'b11;

    // An illegal code is never displayed; red is the safe fallback.
    function automatic lamp_t decode_light(input light_t code);
        lamp_t lamp;
        case (code)
            LIGHT_AMBER: lamp = LAMP_AMBER;
            LIGHT_GREEN: lamp = LAMP_GREEN;
            default:     lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/lamp_flasher.sv
// -----------------------------------------------------------------------------
// lamp_flasher
// Flash phase generator for the failsafe mode. Phase is "on" right after a
// restart and toggles every FLASH_HALF_PERIOD enabled cycles.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset (phase on, counter 0)
//   enable  in   advance the flash counter this cycle
//   restart in   force counter 0 and phase on (has priority over enable)
//   phase   out  1 = lamps on, 0 = lamps off
// -----------------------------------------------------------------------------
module lamp_flasher #(
    parameter int FLASH_HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic phase
);

    localparam int CW = $clog2(FLASH_HALF_PERIOD + 1);

    logic [CW-1:0] flash_cnt_reg;
    logic          phase_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_cnt_reg <= '0;
            phase_reg     <= 1'b1;
        end else if (restart) begin
            flash_cnt_reg <= '0;
            phase_reg     <= 1'b1;
        end else if (enable) begin
            if (flash_cnt_reg == CW'(FLASH_HALF_PERIOD - 1)) begin
                flash_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                flash_cnt_reg <= flash_cnt_reg + 1'b1;
            end
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/lamp_safety_monitor.sv
// -----------------------------------------------------------------------------
// lamp_safety_monitor
// Safety stage between the traffic-light controller and the lamp drivers.
// Never displays conflicting greens or illegal codes; persistent faults latch
// a flashing-red failsafe that exits only via operator-acknowledged, timed
// all-red recovery.
// Optional feature: define LAMP_FAULT_CODE_EN to latch the fault cause on
// fault_code; otherwise fault_code is constant 00.
// Ports:
//   clk                          in   system clock, rising edge
//   rst                          in   asynchronous active-low reset
//   north/west/south/east_light  in   2-bit controller light codes
//   fault_clear                  in   operator acknowledge (level)
//   north/west/south/east_lamp   out  one-hot {red, amber, green}
//   fault                        out  high while in FLASH
//   fault_code                   out  latched cause: 01 conflict, 10 illegal, 11 both
// -----------------------------------------------------------------------------
module lamp_safety_monitor
    import traffic_pkg::*;
#(
    parameter int CONFLICT_PERSIST  = 2,
    parameter int FLASH_HALF_PERIOD = 4,
    parameter int MIN_FAULT_CYCLES  = 16,
    parameter int RECOVER_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] north_light,
    input  logic [1:0] west_light,
    input  logic [1:0] south_light,
    input  logic [1:0] east_light,
    input  logic       fault_clear,
    output logic [2:0] north_lamp,
    output logic [2:0] west_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] east_lamp,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int BW = $clog2(CONFLICT_PERSIST + 1);
    localparam int FW = (MIN_FAULT_CYCLES > 0) ? $clog2(MIN_FAULT_CYCLES + 1) : 1;
    localparam int RW = $clog2(RECOVER_CYCLES + 1);

    // Index order: 0 north, 1 west, 2 south, 3 east
    light_t light_in [4];
    lamp_t  lamp_reg [4];
    lamp_t  lamp_out [4];

    assign light_in[0] = north_light;
    assign light_in[1] = west_light;
    assign light_in[2] = south_light;
    assign light_in[3] = east_light;

    monitor_state_t state_reg, state_next;

    logic [BW-1:0] bad_cnt_reg;
    logic [FW-1:0] fault_cycles_reg;
    logic [RW-1:0] recover_cnt_reg;

    logic any_illegal, ns_active, ew_active, conflict, bad_cycle;
    logic all_red_in, persist_hit, clear_ok, flash_entry, flash_phase;

    // Any non-red code (including illegal) counts as an active direction.
    assign any_illegal = (north_light == LIGHT_ILLEGAL) || (west_light == LIGHT_ILLEGAL) ||
                         (south_light == LIGHT_ILLEGAL) || (east_light == LIGHT_ILLEGAL);
    assign ns_active   = (north_light != LIGHT_RED) || (south_light != LIGHT_RED);
    assign ew_active   = (east_light  != LIGHT_RED) || (west_light  != LIGHT_RED);
    assign conflict    = ns_active && ew_active;
    assign bad_cycle   = any_illegal || conflict;
    assign all_red_in  = !ns_active && !ew_active;

    // This bad cycle is the one that completes the persistence window.
    assign persist_hit = bad_cycle && (bad_cnt_reg == BW'(CONFLICT_PERSIST - 1));
    assign clear_ok    = fault_clear && all_red_in &&
                         (fault_cycles_reg >= FW'(MIN_FAULT_CYCLES));
    assign flash_entry = (state_next == FLASH) && (state_reg != FLASH);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= NORMAL;
        else      state_reg <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            NORMAL:  if (persist_hit) state_next = FLASH;
            FLASH:   if (clear_ok)    state_next = RECOVER;
            RECOVER: begin
                // Persistence beats recovery completion on the same cycle.
                if (persist_hit)
                    state_next = FLASH;
                else if (recover_cnt_reg == RW'(RECOVER_CYCLES - 1))
                    state_next = NORMAL;
            end
            default: state_next = NORMAL;
        endcase
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_cnt_reg      <= '0;
            fault_cycles_reg <= '0;
            recover_cnt_reg  <= '0;
        end else begin
            if (!bad_cycle)
                bad_cnt_reg <= '0;
            else if (bad_cnt_reg != BW'(CONFLICT_PERSIST))
                bad_cnt_reg <= bad_cnt_reg + 1'b1;

            // Held at 0 outside FLASH so every entry starts counting from 0.
            if (state_reg != FLASH)
                fault_cycles_reg <= '0;
            else if (fault_cycles_reg != FW'(MIN_FAULT_CYCLES))
                fault_cycles_reg <= fault_cycles_reg + 1'b1;

            if (state_reg != RECOVER)
                recover_cnt_reg <= '0;
            else if (recover_cnt_reg != RW'(RECOVER_CYCLES))
                recover_cnt_reg <= recover_cnt_reg + 1'b1;
        end
    end

    // Display register: loaded every cycle so it is already valid on the
    // edge that returns to NORMAL. Bad cycles load steady red.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)           lamp_reg[gi] <= LAMP_RED;
                else if (bad_cycle) lamp_reg[gi] <= LAMP_RED;
                else                lamp_reg[gi] <= decode_light(light_in[gi]);
            end
        end
    endgenerate

    lamp_flasher #(
        .FLASH_HALF_PERIOD (FLASH_HALF_PERIOD)
    ) u_flasher (
        .clk     (clk),
        .rst     (rst),
        .enable  (state_reg == FLASH),
        .restart (flash_entry),
        .phase   (flash_phase)
    );

    // ---------------- output logic ----------------
    always_comb begin
        fault = (state_reg == FLASH);
        for (int i = 0; i < 4; i++) begin
            case (state_reg)
                NORMAL:  lamp_out[i] = lamp_reg[i];
                FLASH:   lamp_out[i] = flash_phase ? LAMP_RED : LAMP_OFF;
                default: lamp_out[i] = LAMP_RED;
            endcase
        end
    end

    assign north_lamp = lamp_out[0];
    assign west_lamp  = lamp_out[1];
    assign south_lamp = lamp_out[2];
    assign east_lamp  = lamp_out[3];

`ifdef LAMP_FAULT_CODE_EN
    logic [1:0] fault_code_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fault_code_reg <= FAULT_NONE;
        else if (flash_entry)
            fault_code_reg <= {any_illegal, conflict};
        else if ((state_next == NORMAL) && (state_reg != NORMAL))
            fault_code_reg <= FAULT_NONE;
    end

    assign fault_code = fault_code_reg;
`else
    assign fault_code = FAULT_NONE;
`endif

endmodule

// File: tb/tb_lamp_safety_monitor.sv
// -----------------------------------------------------------------------------
// tb_lamp_safety_monitor
// Directed scenarios followed by biased random traffic, every cycle compared
// against a cycle-level reference model that tracks elapsed time per mode.
// -----------------------------------------------------------------------------
module tb_lamp_safety_monitor;

    localparam int CP  = 2;
    localparam int HP  = 4;
    localparam int MFC = 16;
    localparam int RC  = 8;

    localparam int M_NORMAL  = 0;
    localparam int M_FLASH   = 1;
    localparam int M_RECOVER = 2;

    logic       clk;
    logic       rst;
    logic [1:0] lights   [4];   // 0 north, 1 west, 2 south, 3 east
    logic [2:0] lamp_obs [4];
    logic       fault_clear;
    logic       fault;
    logic [1:0] fault_code;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;

    // reference model state
    int         m_mode;
    int         m_bad;     // consecutive bad cycles (saturating)
    int         m_t;       // cycles since FLASH entry
    int         m_r;       // cycles since RECOVER entry
    logic [2:0] m_disp [4];
    logic [1:0] m_code;

    lamp_safety_monitor #(
        .CONFLICT_PERSIST  (CP),
        .FLASH_HALF_PERIOD (HP),
        .MIN_FAULT_CYCLES  (MFC),
        .RECOVER_CYCLES    (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .north_light (lights[0]),
        .west_light  (lights[1]),
        .south_light (lights[2]),
        .east_light  (lights[3]),
        .fault_clear (fault_clear),
        .north_lamp  (lamp_obs[0]),
        .west_lamp   (lamp_obs[1]),
        .south_lamp  (lamp_obs[2]),
        .east_lamp   (lamp_obs[3]),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [2:0] lamp_of(input logic [1:0] code);
        if (code == 2'b01) return 3'b010;
        if (code == 2'b10) return 3'b001;
        return 3'b100;
    endfunction

    task automatic model_reset();
        m_mode = M_NORMAL;
        m_bad  = 0;
        m_t    = 0;
        m_r    = 0;
        m_code = 2'b00;
        for (int i = 0; i < 4; i++) m_disp[i] = 3'b100;
    endtask

    // One rising edge of the reference, using the inputs sampled at that edge.
    task automatic model_step();
        bit illegal, ns, ew, bad, hit, allred;
        illegal = 0;
        for (int i = 0; i < 4; i++) if (lights[i] == 2'b11) illegal = 1;
        ns     = (lights[0] != 0) || (lights[2] != 0);
        ew     = (lights[1] != 0) || (lights[3] != 0);
        bad    = illegal || (ns && ew);
        allred = !ns && !ew;
        hit    = bad && (m_bad == CP - 1);
        m_bad  = bad ? ((m_bad < CP) ? m_bad + 1 : CP) : 0;
        for (int i = 0; i < 4; i++) m_disp[i] = bad ? 3'b100 : lamp_of(lights[i]);
        case (m_mode)
            M_NORMAL: if (hit) begin
                m_mode = M_FLASH; m_t = 0; m_code = {illegal, ns && ew};
            end
            M_FLASH: begin
                if (fault_clear && allred && m_t >= MFC) begin
                    m_mode = M_RECOVER; m_r = 0;
                end else begin
                    m_t++;
                end
            end
            default: begin
                if (hit) begin
                    m_mode = M_FLASH; m_t = 0; m_code = {illegal, ns && ew};
                end else if (m_r == RC - 1) begin
                    m_mode = M_NORMAL; m_code = 2'b00;
                end else begin
                    m_r++;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [2:0] exp_lamp;
        logic [1:0] exp_code;
        for (int i = 0; i < 4; i++) begin
            if (m_mode == M_NORMAL)     exp_lamp = m_disp[i];
            else if (m_mode == M_FLASH) exp_lamp = ((m_t / HP) % 2 == 0) ? 3'b100 : 3'b000;
            else                        exp_lamp = 3'b100;
            case (i)
                0:       check("north_lamp", 32'(lamp_obs[i]), 32'(exp_lamp));
                1:       check("west_lamp",  32'(lamp_obs[i]), 32'(exp_lamp));
                2:       check("south_lamp", 32'(lamp_obs[i]), 32'(exp_lamp));
                default: check("east_lamp",  32'(lamp_obs[i]), 32'(exp_lamp));
            endcase
        end
        check("fault", 32'(fault), 32'(m_mode == M_FLASH));
`ifdef LAMP_FAULT_CODE_EN
        exp_code = m_code;
`else
        exp_code = 2'b00;
`endif
        check("fault_code", 32'(fault_code), 32'(exp_code));
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic cycle(input logic [1:0] n, input logic [1:0] w, input logic [1:0] s,
                         input logic [1:0] e, input logic clr);
        lights[0] = n; lights[1] = w; lights[2] = s; lights[3] = e;
        fault_clear = clr;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_outputs();
        $display("cyc %0d in N%0d W%0d S%0d E%0d clr%0d -> lamps %b %b %b %b fault %0d code %b",
                 cyc, n, w, s, e, clr, lamp_obs[0], lamp_obs[1], lamp_obs[2], lamp_obs[3],
                 fault, fault_code);
    endtask

    // Assert reset between edges and check the outputs react without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst_fault", 32'(fault), 32'd0);
        $display("async reset applied at %0t", $time);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic random_cycle();
        int r;
        logic [1:0] l [4];
        r = $urandom_range(0, 99);
        for (int i = 0; i < 4; i++) l[i] = 2'b00;
        if (r < 20) begin
            // all red
        end else if (r < 55) begin
            l[0] = 2'($urandom_range(0, 2)); l[2] = 2'($urandom_range(0, 2));
        end else if (r < 80) begin
            l[1] = 2'($urandom_range(0, 2)); l[3] = 2'($urandom_range(0, 2));
        end else if (r < 95) begin
            l[0] = 2'($urandom_range(1, 2)); l[3] = 2'($urandom_range(1, 2));
            l[2] = 2'($urandom_range(0, 2));
        end else begin
            for (int i = 0; i < 4; i++) l[i] = 2'($urandom_range(0, 2));
            l[$urandom_range(0, 3)] = 2'b11;
        end
        cycle(l[0], l[1], l[2], l[3], 1'($urandom_range(0, 99) < 40));
    endtask

    initial begin
        rst = 1'b0;
        fault_clear = 1'b0;
        for (int i = 0; i < 4; i++) lights[i] = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check("reset_lamp", 32'(lamp_obs[i]), 32'h4);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_code", 32'(fault_code), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // NS green
        cycle(2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
        check("ns_green", 32'(lamp_obs[0]), 32'h1);
        // single-cycle conflict glitches never latch
        cycle(2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
        cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        cycle(2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
        cycle(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        check("glitch_no_fault", 32'(fault), 32'd0);
        // held conflict -> FLASH on second edge
        cycle(2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
        cycle(2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
        check("latched", 32'(fault), 32'd1);
        repeat (9) cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);          // too early
        repeat (6) cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b1);          // non-red input
        cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);          // accepted
        check("cleared", 32'(fault), 32'd0);
        repeat (3) cycle(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b11, 2'b00, 2'b00, 1'b0);          // back to FLASH
        check("refault", 32'(fault), 32'd1);
        repeat (20) cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        repeat (RC + 2) cycle(2'b00, 2'b01, 2'b00, 2'b10, 1'b0);
        // reset mid-FLASH
        cycle(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        cycle(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        repeat (3) cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        async_reset();
        cycle(2'b00, 2'b01, 2'b00, 2'b10, 1'b0);

        for (int k = 0; k < 2000; k++) begin
            if (k % 700 == 699) async_reset();
            random_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/lamp_safety_monitor.md
# lamp_safety_monitor

- Sits directly downstream of the traffic-light controller.
- Consumes the four 2-bit direction light codes and drives one-hot red/amber/green lamp outputs.
- Detects conflicting greens or illegal codes and never displays them; a persistent fault latches a flashing-red failsafe mode.
- The failsafe exits only through an operator-acknowledged, timed all-red recovery.

## Interface
- CONFLICT_PERSIST, 2: consecutive bad cycles needed to latch a fault (≥1).
- FLASH_HALF_PERIOD, 4: cycles per on/off half of the failsafe flash (≥1).
- MIN_FAULT_CYCLES, 16: minimum cycles in FLASH before fault_clear is honoured.
- RECOVER_CYCLES, 8: steady all-red cycles in RECOVER before returning to NORMAL (≥1).
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- north_light / west_light / south_light / east_light  input  2 each  controller codes: 00 red, 01 amber, 10 green, 11 illegal.
- fault_clear  input  1  operator acknowledge, level sampled each cycle.
- north_lamp / west_lamp / south_lamp / east_lamp  output  3 each  one-hot {red, amber, green}.
- fault  output  1  high while in FLASH.
- fault_code  output  2  latched cause: 01 conflict, 10 illegal code, 11 both.

## Operation
- **Bad cycle:** a cycle is bad if any input is 11, or if (N or S non-red) and (E or W non-red).
- **bad_cnt:**
  - increments on each bad cycle, saturating at CONFLICT_PERSIST;
  - clears to 0 on any good cycle;
  - counts in every state.
- **NORMAL:**
  - good cycle: lamps load the decoded inputs (00→100, 01→010, 10→001);
  - bad cycle: all lamps load 100 (steady red), so a conflict is never displayed;
  - a bad cycle with bad_cnt == CONFLICT_PERSIST-1 moves the state to FLASH.
- **FLASH:**
  - fault = 1;
  - every lamp is red when flash phase = on, 000 when off;
  - phase starts on at entry and toggles every FLASH_HALF_PERIOD cycles;
  - fault_cycles counts from 0 at entry, saturating.
  - fault_clear is accepted when all of these hold in the same cycle:
    - fault_clear = 1;
    - fault_cycles ≥ MIN_FAULT_CYCLES;
    - all four inputs = 00.
  - Accepted → RECOVER. Otherwise fault_clear is ignored and not remembered.
- **RECOVER:**
  - fault = 0; all lamps steady 100; inputs are not displayed;
  - NORMAL after RECOVER_CYCLES cycles;
  - a bad cycle that completes persistence returns to FLASH and restarts the phase and fault_cycles.
- **Simultaneous events:**
  - fault_clear with any non-red input is rejected;
  - persistence reached on the same cycle RECOVER would finish → FLASH wins.
- **Widths:** counters are $clog2(param+1) bits and saturate; no wrap-around.

## Timing
- Reset values:
  - all lamps 100;
  - fault 0, fault_code 00;
  - state NORMAL;
  - bad_cnt, fault_cycles and flash counter 0; phase on.
- Reset asserted mid-FLASH or mid-RECOVER returns to these values immediately (async).
- Latency: NORMAL lamps show the input sampled at edge k after edge k (1 cycle, registered).
- Fault latch: with CONFLICT_PERSIST=2, bad inputs at edges k and k+1 give:
  - steady all-red after edge k;
  - fault=1 and red flash-on after edge k+1.
- Flash: red lamp high for exactly FLASH_HALF_PERIOD cycles, then low for FLASH_HALF_PERIOD cycles, repeating.
- Clear: accepted at edge j gives fault=0 after j; NORMAL lamps from edge j+RECOVER_CYCLES.

## Configuration
- LAMP_FAULT_CODE_EN defined:
  - fault_code loads the cause from the cycle that latches FLASH;
  - it holds through FLASH and RECOVER and clears to 00 on entering NORMAL;
  - each new FLASH entry overwrites it.
- LAMP_FAULT_CODE_EN undefined: fault_code is constant 00; no cause logic is synthesised.

## Structure
- Shared package traffic_pkg holds:
  - light code constants (LIGHT_RED, LIGHT_AMBER, LIGHT_GREEN, LIGHT_ILLEGAL);
  - lamp one-hot constants (LAMP_RED=100, LAMP_AMBER=010, LAMP_GREEN=001, LAMP_OFF=000);
  - monitor state enum (NORMAL, FLASH, RECOVER);
  - fault_code constants.
- One sub-module: lamp_flasher.
  - Ports: enable, restart, phase output.
  - Parameterised by FLASH_HALF_PERIOD.
  - Owns the flash counter and phase toggle.

## Test plan
- Reset, then drive N=10, S=10, E=00, W=00 → after 1 edge north_lamp=south_lamp=001, east/west=100, fault=0.
- One-cycle glitch N=10, E=10, then legal → lamps 100 for one cycle, fault stays 0, bad_cnt back to 0.
- N=10, E=10 held → fault=1 on 2nd edge, fault_code=01 (macro on); red toggles every 4 cycles.
- fault_clear at fault_cycles=10 with all-red inputs → ignored. fault_clear at cycle 16 with N=01 → ignored. fault_clear at cycle 16 with all 00 → fault=0, lamps 100 for 8 cycles, then NORMAL.
- In RECOVER drive W=11 for 2 cycles → back to FLASH, fault_code=10, flash restarts phase-on.
- Assert rst mid-FLASH → lamps 100, fault 0, fault_code 00 immediately; legal inputs after release display normally.
